// File: rtl/dram_pkg.sv
// Shared DRAM command encodings, row-status codes and default timing.
package dram_pkg;

  localparam int unsigned ROW_BITS = 16;

  localparam int unsigned T_RP_DEF  = 4;
  localparam int unsigned T_RCD_DEF = 4;
  localparam int unsigned T_CL_DEF  = 4;
  localparam int unsigned T_RFC_DEF = 16;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_PRE  = 3'd2,
    CMD_PREA = 3'd3,
    CMD_RD   = 3'd4,
    CMD_WR   = 3'd5,
    CMD_REF  = 3'd6
  } cmd_t;

  localparam logic [1:0] ROW_IDLE     = 2'b00;
  localparam logic [1:0] ROW_HIT      = 2'b01;
  localparam logic [1:0] ROW_MISS     = 2'b10;
  localparam logic [1:0] ROW_CONFLICT = 2'b11;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/row_open_if.sv
// Connection between the command sequencer (master) and the row-open tracker (slave).
interface row_open_if;
  import dram_pkg::*;

  logic                req_en;
  logic                refresh;
  logic                row_resolve;
  logic                tACT_done;
  logic [1:0]          bank_group;
  logic [1:0]          bank;
  logic [ROW_BITS-1:0] row;
  logic [1:0]          row_stat;
  logic                all_row_closed;

  modport master (
    output req_en, refresh, row_resolve, tACT_done, bank_group, bank, row,
    input  row_stat, all_row_closed
  );

  modport slave (
    input  req_en, refresh, row_resolve, tACT_done, bank_group, bank, row,
    output row_stat, all_row_closed
  );

endinterface

// File: rtl/dram_cmd_seq.sv
// Per-request DRAM command sequencer: PRE/ACT/RD/WR with tRP/tRCD/tCL spacing,
// plus the PREA/REF refresh sequence, steered by the row-open tracker.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting; refresh_req wins over req_valid
// CHECK      | query tracker (req_en), branch on row_stat
// PRE        | precharge requested bank, tell tracker row resolved
// PRE_WAIT   | tRP spacing before ACT
// ACT        | activate requested row
// ACT_WAIT   | tRCD spacing, tACT_done on last cycle
// COL        | RD or WR
// COL_WAIT   | tCL data window, req_done on last cycle
// REF_PRE    | precharge all banks before refresh
// REF_PWAIT  | tRP spacing before REF
// REF_CMD    | refresh command
// REF_WAIT   | tRFC spacing, refresh_ack on last cycle
module dram_cmd_seq
  import dram_pkg::*;
#(
  parameter int unsigned tRP  = T_RP_DEF,
  parameter int unsigned tRCD = T_RCD_DEF,
  parameter int unsigned tCL  = T_CL_DEF,
  parameter int unsigned tRFC = T_RFC_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [1:0]          req_bg,
  input  logic [1:0]          req_bank,
  input  logic [ROW_BITS-1:0] req_row,
  output logic                req_done,
  input  logic                refresh_req,
  output logic                refresh_ack,
  row_open_if.master          ro,
  output cmd_t                cmd,
  output logic [1:0]          cmd_bg,
  output logic [1:0]          cmd_bank,
  output logic [ROW_BITS-1:0] cmd_row
);

  localparam int unsigned T_MAX = max4(tRP, tRCD, tCL, tRFC);
  localparam int unsigned CW    = $clog2(T_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_PRE,
    S_PRE_WAIT,
    S_ACT,
    S_ACT_WAIT,
    S_COL,
    S_COL_WAIT,
    S_REF_PRE,
    S_REF_PWAIT,
    S_REF_CMD,
    S_REF_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_en, refresh, row_resolve, tact_done;
  logic          last;

  assign ro.req_en      = req_en;
  assign ro.refresh     = refresh;
  assign ro.row_resolve = row_resolve;
  assign ro.tACT_done   = tact_done;
  assign ro.bank_group  = req_bg;
  assign ro.bank        = req_bank;
  assign ro.row         = req_row;

  // Waits exit on the cycle the counter reads 1, so a load of N gives N wait cycles.
  assign last = (cnt_q <= CW'(1));

  // State and timing-counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter load/decrement and Moore outputs per state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    cmd         = CMD_NOP;
    cmd_bg      = 2'b00;
    cmd_bank    = 2'b00;
    cmd_row     = '0;
    req_done    = 1'b0;
    refresh_ack = 1'b0;
    req_en      = 1'b0;
    refresh     = 1'b0;
    row_resolve = 1'b0;
    tact_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (refresh_req) begin
          state_d = ro.all_row_closed ? S_REF_CMD : S_REF_PRE;
        end else if (req_valid) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        req_en = 1'b1;
        case (ro.row_stat)
          ROW_HIT:      state_d = S_COL;
          ROW_MISS:     state_d = S_ACT;
          ROW_CONFLICT: state_d = S_PRE;
          default:      state_d = S_IDLE;
        endcase
      end
      S_PRE: begin
        cmd         = CMD_PRE;
        cmd_bg      = req_bg;
        cmd_bank    = req_bank;
        row_resolve = 1'b1;
        cnt_d       = CW'(tRP);
        state_d     = S_PRE_WAIT;
      end
      S_PRE_WAIT: begin
        if (last) state_d = S_ACT;
      end
      S_ACT: begin
        cmd      = CMD_ACT;
        cmd_bg   = req_bg;
        cmd_bank = req_bank;
        cmd_row  = req_row;
        cnt_d    = CW'(tRCD);
        state_d  = S_ACT_WAIT;
      end
      S_ACT_WAIT: begin
        if (last) begin
          tact_done = 1'b1;
          state_d   = S_COL;
        end
      end
      S_COL: begin
        cmd      = req_write ? CMD_WR : CMD_RD;
        cmd_bg   = req_bg;
        cmd_bank = req_bank;
        cnt_d    = CW'(tCL);
        state_d  = S_COL_WAIT;
      end
      S_COL_WAIT: begin
        if (last) begin
          req_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_REF_PRE: begin
        cmd     = CMD_PREA;
        refresh = 1'b1;
        cnt_d   = CW'(tRP);
        state_d = S_REF_PWAIT;
      end
      S_REF_PWAIT: begin
        refresh = 1'b1;
        if (last) state_d = S_REF_CMD;
      end
      S_REF_CMD: begin
        cmd     = CMD_REF;
        refresh = 1'b1;
        cnt_d   = CW'(tRFC);
        state_d = S_REF_WAIT;
      end
      S_REF_WAIT: begin
        refresh = 1'b1;
        if (last) begin
          refresh_ack = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dram_cmd_seq.sv
// Self-checking bench for dram_cmd_seq: directed table, randomized scenarios
// against a timeline model, and reset corner cases.
module tb_dram_cmd_seq;
  import dram_pkg::*;

  localparam int MAXC = 64;
  localparam int TRP  = T_RP_DEF;
  localparam int TRCD = T_RCD_DEF;
  localparam int TCL  = T_CL_DEF;
  localparam int TRFC = T_RFC_DEF;

  // flag bit positions in the per-cycle flag vector
  localparam int F_ACK = 0, F_REF = 1, F_DONE = 2, F_TACT = 3, F_RR = 4, F_REQEN = 5;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_write = 1'b0;
  logic [1:0]          req_bg = 2'b00;
  logic [1:0]          req_bank = 2'b00;
  logic [ROW_BITS-1:0] req_row = '0;
  logic                req_done;
  logic                refresh_req = 1'b0;
  logic                refresh_ack;
  cmd_t                cmd;
  logic [1:0]          cmd_bg, cmd_bank;
  logic [ROW_BITS-1:0] cmd_row;

  row_open_if ro_if ();

  dram_cmd_seq dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_bg      (req_bg),
    .req_bank    (req_bank),
    .req_row     (req_row),
    .req_done    (req_done),
    .refresh_req (refresh_req),
    .refresh_ack (refresh_ack),
    .ro          (ro_if),
    .cmd         (cmd),
    .cmd_bg      (cmd_bg),
    .cmd_bank    (cmd_bank),
    .cmd_row     (cmd_row)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit                  write;
    logic [1:0]          bg;
    logic [1:0]          bank;
    logic [ROW_BITS-1:0] row;
    logic [1:0]          stat;
    int                  retries;
    bit                  ref_first;
    bit                  closed;
    int                  mid_ref;   // cycle at which refresh_req rises, 0 = never
    int                  exp_done;  // hand-computed req_done cycle, -1 = unknown
  } vec_t;

  typedef logic [3+2+2+ROW_BITS-1:0] trace_t;

  trace_t     e_trace [MAXC];
  trace_t     o_trace [MAXC];
  logic [5:0] e_flags [MAXC];
  logic [5:0] o_flags [MAXC];
  int         m_len, m_check, m_done;
  string      flag_names [6] = '{"refresh_ack", "ro.refresh", "req_done",
                                 "tACT_done", "row_resolve", "req_en"};

  task automatic check(input string name, input bit ok, input string detail);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic trace_t pack(input cmd_t c, input logic [1:0] bg, input logic [1:0] bk,
                                  input logic [ROW_BITS-1:0] r);
    return {c, bg, bk, r};
  endfunction

  task automatic note_len(input int c);
    if (c + 3 > m_len) m_len = c + 3;
  endtask

  // Timeline of a refresh starting at cycle s; returns the ack cycle.
  task automatic model_refresh(input int s, input bit closed, output int ack);
    int r;
    r = s;
    if (!closed) begin
      e_trace[s] = pack(CMD_PREA, 2'b00, 2'b00, '0);
      r = s + TRP + 1;
    end
    e_trace[r] = pack(CMD_REF, 2'b00, 2'b00, '0);
    ack = r + TRFC;
    for (int k = s; k <= ack; k++) e_flags[k][F_REF] = 1'b1;
    e_flags[ack][F_ACK] = 1'b1;
    note_len(ack);
  endtask

  // Expected per-cycle behaviour; cycle 0 is the IDLE cycle that first sees the inputs.
  task automatic build_model(input vec_t v);
    int base, act, col, pre, ack;
    for (int k = 0; k < MAXC; k++) begin
      e_trace[k] = pack(CMD_NOP, 2'b00, 2'b00, '0);
      e_flags[k] = '0;
    end
    m_len = 0;
    base  = 0;
    act   = -1;
    if (v.ref_first) begin
      model_refresh(1, v.closed, ack);
      base = ack + 1;
    end
    for (int i = 0; i <= v.retries; i++) e_flags[base + 1 + 2 * i][F_REQEN] = 1'b1;
    m_check = base + 1 + 2 * v.retries;
    col = m_check + 1;
    if (v.stat == ROW_MISS) act = m_check + 1;
    if (v.stat == ROW_CONFLICT) begin
      pre = m_check + 1;
      e_trace[pre] = pack(CMD_PRE, v.bg, v.bank, '0);
      e_flags[pre][F_RR] = 1'b1;
      act = pre + TRP + 1;
    end
    if (act >= 0) begin
      e_trace[act] = pack(CMD_ACT, v.bg, v.bank, v.row);
      e_flags[act + TRCD][F_TACT] = 1'b1;
      col = act + TRCD + 1;
    end
    e_trace[col] = pack(v.write ? CMD_WR : CMD_RD, v.bg, v.bank, '0);
    m_done = col + TCL;
    e_flags[m_done][F_DONE] = 1'b1;
    note_len(m_done);
    if (v.mid_ref > 0) model_refresh(m_done + 2, v.closed, ack);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int chk_seen, bad, first_done;
    build_model(v);
    chk_seen = 0;
    for (int k = 0; k < m_len; k++) begin
      @(negedge CLK);
      o_trace[k] = pack(cmd, cmd_bg, cmd_bank, cmd_row);
      o_flags[k] = {ro_if.req_en, ro_if.row_resolve, ro_if.tACT_done, req_done,
                    ro_if.refresh, refresh_ack};
      if (k == 0) begin
        req_write            = v.write;
        req_bg               = v.bg;
        req_bank             = v.bank;
        req_row              = v.row;
        req_valid            = 1'b1;
        refresh_req          = v.ref_first;
        ro_if.all_row_closed = v.closed;
      end
      if (ro_if.req_en === 1'b1) begin
        ro_if.row_stat = (chk_seen < v.retries) ? ROW_IDLE : v.stat;
        chk_seen++;
      end else begin
        ro_if.row_stat = 2'($urandom_range(0, 3));
      end
      if (refresh_ack === 1'b1) refresh_req = 1'b0;
      if (req_done === 1'b1) req_valid = 1'b0;
      if (v.mid_ref > 0 && k == v.mid_ref) refresh_req = 1'b1;
    end

    bad = -1;
    for (int k = 0; k < m_len; k++) if (bad < 0 && o_trace[k] !== e_trace[k]) bad = k;
    if (bad < 0) check({tag, " cmd trace"}, 1'b1, "");
    else check({tag, " cmd trace"}, 1'b0,
               $sformatf("cycle %0d got cmd/bg/bank/row %0d/%0d/%0d/%h, expected %0d/%0d/%0d/%h",
                         bad, o_trace[bad][22:20], o_trace[bad][19:18], o_trace[bad][17:16],
                         o_trace[bad][15:0], e_trace[bad][22:20], e_trace[bad][19:18],
                         e_trace[bad][17:16], e_trace[bad][15:0]));

    for (int b = 0; b < 6; b++) begin
      bad = -1;
      for (int k = 0; k < m_len; k++) if (bad < 0 && o_flags[k][b] !== e_flags[k][b]) bad = k;
      if (bad < 0) check({tag, " ", flag_names[b]}, 1'b1, "");
      else check({tag, " ", flag_names[b]}, 1'b0,
                 $sformatf("cycle %0d got %b, expected %b", bad, o_flags[bad][b], e_flags[bad][b]));
    end

    if (v.exp_done >= 0) begin
      first_done = -1;
      for (int k = 0; k < m_len; k++) if (first_done < 0 && o_flags[k][F_DONE] === 1'b1) first_done = k;
      check({tag, " done latency"}, first_done == v.exp_done,
            $sformatf("req_done at cycle %0d, expected cycle %0d", first_done, v.exp_done));
    end
  endtask

  vec_t table_v [8];
  vec_t rv;
  int   bad_i, seen;

  initial begin
    table_v[0] = '{0, 2'd1, 2'd2, 16'h001A, ROW_HIT,      0, 0, 0, 0,  6};
    table_v[1] = '{1, 2'd1, 2'd2, 16'h001A, ROW_MISS,     0, 0, 0, 0, 11};
    table_v[2] = '{0, 2'd1, 2'd2, 16'h001A, ROW_CONFLICT, 0, 0, 0, 0, 16};
    table_v[3] = '{0, 2'd0, 2'd3, 16'h0055, ROW_HIT,      0, 1, 0, 0, 29};
    table_v[4] = '{1, 2'd2, 2'd1, 16'h0077, ROW_MISS,     0, 1, 1, 0, 29};
    table_v[5] = '{1, 2'd1, 2'd2, 16'h001A, ROW_MISS,     0, 0, 0, 3, 11};
    table_v[6] = '{0, 2'd3, 2'd0, 16'h1234, ROW_HIT,      2, 0, 0, 0, 10};
    table_v[7] = '{1, 2'd3, 2'd3, 16'hFFFF, ROW_CONFLICT, 0, 0, 1, 0, 16};

    // Reset hold with a pending request.
    req_valid            = 1'b1;
    req_bg               = 2'd1;
    req_bank             = 2'd2;
    req_row              = 16'h001A;
    ro_if.row_stat       = ROW_HIT;
    ro_if.all_row_closed = 1'b1;
    bad_i = 0;
    repeat (3) begin
      @(negedge CLK);
      if (cmd !== CMD_NOP || req_done !== 1'b0 || refresh_ack !== 1'b0 ||
          ro_if.req_en !== 1'b0 || ro_if.refresh !== 1'b0 || ro_if.row_resolve !== 1'b0 ||
          ro_if.tACT_done !== 1'b0 || cmd_bg !== 2'b00 || cmd_bank !== 2'b00 || cmd_row !== '0)
        bad_i++;
    end
    check("reset hold", bad_i == 0, $sformatf("%0d cycles with active outputs, expected 0", bad_i));
    RST = 1'b0;
    @(negedge CLK);
    check("first check after reset", ro_if.req_en === 1'b1 && cmd === CMD_NOP,
          $sformatf("req_en=%b cmd=%0d, expected req_en=1 cmd=0", ro_if.req_en, cmd));
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge CLK);
      if (req_done === 1'b1) seen = 1;
    end
    check("post-reset request completes", seen == 1, "req_done not seen within 20 cycles");
    req_valid = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(table_v[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rv.write     = 1'($urandom_range(0, 1));
      rv.bg        = 2'($urandom_range(0, 3));
      rv.bank      = 2'($urandom_range(0, 3));
      rv.row       = ROW_BITS'($urandom);
      rv.stat      = 2'($urandom_range(1, 3));
      rv.retries   = $urandom_range(0, 2);
      rv.ref_first = ($urandom_range(0, 3) == 0);
      rv.closed    = 1'($urandom_range(0, 1));
      rv.mid_ref   = 0;
      rv.exp_done  = -1;
      if (!rv.ref_first && $urandom_range(0, 3) == 0) begin
        build_model(rv);
        rv.mid_ref = $urandom_range(m_check, m_done);
      end
      run_vec(rv, $sformatf("rand%0d", i));
    end

    // Reset during COL_WAIT: the read must never complete.
    @(negedge CLK);
    req_write      = 1'b0;
    req_bg         = 2'd2;
    req_bank       = 2'd1;
    req_row        = 16'h0042;
    ro_if.row_stat = ROW_HIT;
    req_valid      = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("abort setup RD issued", cmd === CMD_RD, $sformatf("cmd=%0d, expected %0d", cmd, CMD_RD));
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("abort reset idle", cmd === CMD_NOP && req_done === 1'b0 && ro_if.req_en === 1'b0,
          $sformatf("cmd=%0d req_done=%b req_en=%b, expected 0/0/0", cmd, req_done, ro_if.req_en));
    RST       = 1'b0;
    req_valid = 1'b0;
    bad_i = 0;
    repeat (10) begin
      @(negedge CLK);
      if (req_done !== 1'b0 || cmd !== CMD_NOP) bad_i++;
    end
    check("abort no completion", bad_i == 0, $sformatf("%0d active cycles after abort, expected 0", bad_i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
